// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: decode, register file, operand resolve, ID/EX register.
// DECODE_FORWARD_EN selects EX/MEM forwarding with load-use stall; otherwise per-register in-flight scoreboard.
module decode_stage #(
   parameter int DATA_WIDTH       = 32,
   parameter int PC_WIDTH         = 32,
   parameter int REGS_WIDTH       = 5,
   parameter int ALU_OPTION_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpu_en,
   input  logic [PC_WIDTH-1:0]         pc,
   input  logic [31:0]                 instruction,
   input  logic                        is_write_regs,
   input  logic [REGS_WIDTH-1:0]       write_address,
   input  logic [DATA_WIDTH-1:0]       write_data,
   input  logic                        ex_fwd_valid,
   input  logic [DATA_WIDTH-1:0]       ex_fwd_data,
   input  logic                        mem_fwd_valid,
   input  logic [REGS_WIDTH-1:0]       mem_fwd_address,
   input  logic [DATA_WIDTH-1:0]       mem_fwd_data,
   output logic                        is_stall,
   output logic [DATA_WIDTH-1:0]       ALU_A,
   output logic [DATA_WIDTH-1:0]       ALU_B,
   output logic [ALU_OPTION_WIDTH-1:0] ALU_option,
   output logic [DATA_WIDTH-1:0]       store_data_future,
   output logic [REGS_WIDTH-1:0]       rd_future,
   output logic                        is_write_regs_future,
   output logic                        is_write_MEM_future,
   output logic                        is_load_future,
   output logic                        is_illegal_future
);
   localparam int NREGS = 2 ** REGS_WIDTH;
   localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LOAD = 7'b0000011,
                          OPC_STORE = 7'b0100011, OPC_LUI = 7'b0110111;
   typedef logic [ALU_OPTION_WIDTH-1:0] aluop_t;

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [DATA_WIDTH-1:0] regs_d [NREGS];
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, store_data_q, store_data_d;
   aluop_t                alu_op_q, alu_op_d;
   logic [REGS_WIDTH-1:0] rd_future_q, rd_future_d;
   logic                  wr_q, wr_d, wm_q, wm_d, ld_q, ld_d, il_q, il_d;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  f7b5;
   logic [REGS_WIDTH-1:0] rd, src [2];
   logic                  dec_legal, dec_wr, dec_wm, dec_ld, use_imm, a_zero;
   logic [1:0]            use_src;
   aluop_t                dec_op;
   logic signed [31:0]    imm32;
   logic [DATA_WIDTH-1:0] opnd [2];
   logic                  stall;
   logic                  unused_pc;

   assign unused_pc = ^pc;
   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign f7b5   = instruction[30];
   assign rd     = REGS_WIDTH'(instruction[11:7]);
   assign src[0] = REGS_WIDTH'(instruction[19:15]);
   assign src[1] = REGS_WIDTH'(instruction[24:20]);

   function automatic aluop_t alu_func(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? aluop_t'(1) : aluop_t'(0);
         3'd1:    return aluop_t'(5);
         3'd2:    return aluop_t'(8);
         3'd3:    return aluop_t'(9);
         3'd4:    return aluop_t'(4);
         3'd5:    return alt ? aluop_t'(7) : aluop_t'(6);
         3'd6:    return aluop_t'(3);
         default: return aluop_t'(2);
      endcase
   endfunction

   always_comb begin
      dec_legal = 1'b0;
      dec_wr    = 1'b0;
      dec_wm    = 1'b0;
      dec_ld    = 1'b0;
      use_imm   = 1'b0;
      a_zero    = 1'b0;
      use_src   = 2'b00;
      dec_op    = aluop_t'(0);
      imm32     = '0;
      case (opcode)
         OPC_OP: begin
            dec_legal = 1'b1; dec_wr = 1'b1; use_src = 2'b11;
            dec_op    = alu_func(funct3, f7b5);
         end
         OPC_IMM: begin
            dec_legal = 1'b1; dec_wr = 1'b1; use_src = 2'b01; use_imm = 1'b1;
            // funct3==0 has no SUB form: bit 30 is immediate data there
            dec_op    = alu_func(funct3, f7b5 && funct3 == 3'd5);
            if (funct3 == 3'd1 || funct3 == 3'd5)
               imm32 = {27'b0, instruction[24:20]};
            else
               imm32 = {{20{instruction[31]}}, instruction[31:20]};
         end
         OPC_LOAD: if (funct3 == 3'd2) begin
            dec_legal = 1'b1; dec_wr = 1'b1; dec_ld = 1'b1; use_src = 2'b01; use_imm = 1'b1;
            imm32     = {{20{instruction[31]}}, instruction[31:20]};
         end
         OPC_STORE: if (funct3 == 3'd2) begin
            dec_legal = 1'b1; dec_wm = 1'b1; use_src = 2'b11; use_imm = 1'b1;
            imm32     = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         end
         OPC_LUI: begin
            dec_legal = 1'b1; dec_wr = 1'b1; use_imm = 1'b1; a_zero = 1'b1;
            imm32     = {instruction[31:12], 12'b0};
         end
         default: ;
      endcase
      if (rd == '0)
         dec_wr = 1'b0;
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         if (src[k] == '0)
            opnd[k] = '0;
`ifdef DECODE_FORWARD_EN
         else if (ex_fwd_valid && !ld_q && rd_future_q == src[k])
            opnd[k] = ex_fwd_data;
         else if (mem_fwd_valid && mem_fwd_address == src[k])
            opnd[k] = mem_fwd_data;
`endif
         else if (is_write_regs && write_address == src[k])
            opnd[k] = write_data;
         else
            opnd[k] = regs_q[src[k]];
      end
   end

`ifdef DECODE_FORWARD_EN
   always_comb begin
      stall = 1'b0;
      for (int k = 0; k < 2; k++)
         if (use_src[k] && ld_q && rd_future_q != '0 && rd_future_q == src[k])
            stall = 1'b1;
   end
`else
   logic [1:0] cnt_q [NREGS];
   logic [1:0] cnt_d [NREGS];
   logic       unused_fwd;
   logic       wb_rd;

   assign unused_fwd = ^{ex_fwd_valid, ex_fwd_data, mem_fwd_valid, mem_fwd_address, mem_fwd_data};
   assign wb_rd      = is_write_regs && write_address == rd;

   always_comb begin
      stall = dec_wr && cnt_q[rd] == 2'd3 && !wb_rd;
      // a lone outstanding write retiring through the WB port this cycle is read via the bypass
      for (int k = 0; k < 2; k++)
         if (use_src[k] && src[k] != '0 && cnt_q[src[k]] != 2'd0 &&
             !(is_write_regs && write_address == src[k] && cnt_q[src[k]] == 2'd1))
            stall = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!stall && dec_wr && rd == REGS_WIDTH'(i)) begin
            if (!(is_write_regs && write_address == REGS_WIDTH'(i) && cnt_q[i] != 2'd0))
               cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (is_write_regs && write_address == REGS_WIDTH'(i) && cnt_q[i] != 2'd0)
            cnt_d[i] = cnt_q[i] - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            cnt_q[i] <= 2'd0;
      end else if (cpu_en) begin
         for (int i = 0; i < NREGS; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end
`endif

   assign is_stall = stall;

   always_comb begin
      for (int i = 0; i < NREGS; i++)
         regs_d[i] = regs_q[i];
      if (is_write_regs && write_address != '0)
         regs_d[write_address] = write_data;
   end

   always_comb begin
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_op_d     = aluop_t'(0);
      store_data_d = '0;
      rd_future_d  = '0;
      wr_d         = 1'b0;
      wm_d         = 1'b0;
      ld_d         = 1'b0;
      il_d         = !stall && !dec_legal && instruction != 32'd0;
      if (!stall && dec_legal) begin
         alu_a_d      = a_zero ? '0 : opnd[0];
         alu_b_d      = use_imm ? DATA_WIDTH'(imm32) : opnd[1];
         alu_op_d     = dec_op;
         store_data_d = dec_wm ? opnd[1] : '0;
         rd_future_d  = dec_wr ? rd : '0;
         wr_d         = dec_wr;
         wm_d         = dec_wm;
         ld_d         = dec_ld;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         store_data_q <= '0;
         rd_future_q  <= '0;
         wr_q         <= 1'b0;
         wm_q         <= 1'b0;
         ld_q         <= 1'b0;
         il_q         <= 1'b0;
      end else if (cpu_en) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= regs_d[i];
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         store_data_q <= store_data_d;
         rd_future_q  <= rd_future_d;
         wr_q         <= wr_d;
         wm_q         <= wm_d;
         ld_q         <= ld_d;
         il_q         <= il_d;
      end
   end

   assign ALU_A                = alu_a_q;
   assign ALU_B                = alu_b_q;
   assign ALU_option           = alu_op_q;
   assign store_data_future    = store_data_q;
   assign rd_future            = rd_future_q;
   assign is_write_regs_future = wr_q;
   assign is_write_MEM_future  = wm_q;
   assign is_load_future       = ld_q;
   assign is_illegal_future    = il_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage; vectors follow DECODE_FORWARD_EN.
module tb_decode_stage;
   typedef struct packed {
      logic [31:0] a, b;
      logic [3:0]  op;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        wr, wm, ld, il;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, cpu_en = 1'b1;
   logic [31:0] pc = 32'd0, instruction = 32'd0;
   logic        is_write_regs = 1'b0, ex_fwd_valid = 1'b0, mem_fwd_valid = 1'b0;
   logic [4:0]  write_address = 5'd0, mem_fwd_address = 5'd0;
   logic [31:0] write_data = 32'd0, ex_fwd_data = 32'd0, mem_fwd_data = 32'd0;
   logic        is_stall;
   logic [31:0] ALU_A, ALU_B, store_data_future;
   logic [3:0]  ALU_option;
   logic [4:0]  rd_future;
   logic        is_write_regs_future, is_write_MEM_future, is_load_future, is_illegal_future;

   int    checks = 0, errors = 0;
   exp_t  expq[$];
   string nameq[$];

   decode_stage dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .pc(pc), .instruction(instruction),
      .is_write_regs(is_write_regs), .write_address(write_address), .write_data(write_data),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_address(mem_fwd_address), .mem_fwd_data(mem_fwd_data),
      .is_stall(is_stall), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_option(ALU_option),
      .store_data_future(store_data_future), .rd_future(rd_future),
      .is_write_regs_future(is_write_regs_future), .is_write_MEM_future(is_write_MEM_future),
      .is_load_future(is_load_future), .is_illegal_future(is_illegal_future)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] a, b, input logic [3:0] op, input logic [31:0] sd,
                               input logic [4:0] rd, input logic wr, wm, ld, il);
      exp_t e;
      e.a = a; e.b = b; e.op = op; e.sd = sd; e.rd = rd;
      e.wr = wr; e.wm = wm; e.ld = ld; e.il = il;
      return e;
   endfunction

   localparam logic [31:0] ADDI_X3 = 32'h00300193, LW_X1 = 32'h0641A083, ADDI_X2 = 32'h06408113,
                           ADD_X2 = 32'h00208133, SW_X0 = 32'h00002423, ILL = 32'h0000007F,
                           ADDI_M1 = 32'hFFF00213, SUB_X5 = 32'h403082B3, SRAI_X6 = 32'h4020D313,
                           LUI_X7 = 32'h123453B7;

   task automatic step(input string nm, input logic [31:0] ins, input logic st, input exp_t e,
                       input logic wb = 1'b0, input logic [4:0] wa = 5'd0, input logic [31:0] wd = 32'd0,
                       input logic en = 1'b1, input logic rs = 1'b0,
                       input logic exv = 1'b0, input logic [31:0] exd = 32'd0,
                       input logic mv = 1'b0, input logic [4:0] ma = 5'd0, input logic [31:0] md = 32'd0);
      @(negedge clk);
      instruction = ins; is_write_regs = wb; write_address = wa; write_data = wd;
      cpu_en = en; rst = rs; ex_fwd_valid = exv; ex_fwd_data = exd;
      mem_fwd_valid = mv; mem_fwd_address = ma; mem_fwd_data = md;
      pc = pc + 32'd4;
      #1;
      checks++;
      if (is_stall !== st) begin
         errors++;
         $display("FAIL %s is_stall: got %b expected %b", nm, is_stall, st);
      end
      expq.push_back(e);
      nameq.push_back(nm);
   endtask

   always begin
      exp_t  e, g;
      string n;
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         n = nameq.pop_front();
         g = mk(ALU_A, ALU_B, ALU_option, store_data_future, rd_future, is_write_regs_future,
                is_write_MEM_future, is_load_future, is_illegal_future);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h op=%0d sd=%h rd=%0d wr=%b wm=%b ld=%b il=%b, expected a=%h b=%h op=%0d sd=%h rd=%0d wr=%b wm=%b ld=%b il=%b",
                     n, g.a, g.b, g.op, g.sd, g.rd, g.wr, g.wm, g.ld, g.il,
                     e.a, e.b, e.op, e.sd, e.rd, e.wr, e.wm, e.ld, e.il);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t z;
      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset0", 32'd0, 1'b0, z, 0, 0, 0, 1, 1);
      step("reset1", ADDI_X3, 1'b0, z, 0, 0, 0, 1, 1);
`ifdef DECODE_FORWARD_EN
      step("addi_x3", ADDI_X3, 1'b0, mk(0, 3, 0, 0, 3, 1, 0, 0, 0));
      step("lw_exfwd", LW_X1, 1'b0, mk(3, 100, 0, 0, 1, 1, 0, 1, 0), 0, 0, 0, 1, 0, 1, 32'd3);
      step("load_use", ADDI_X2, 1'b1, z);
      step("memfwd", ADDI_X2, 1'b0, mk(32'h77, 100, 0, 0, 2, 1, 0, 0, 0),
           0, 0, 0, 1, 0, 0, 0, 1, 5'd1, 32'h77);
      step("ex_wb_fwd", ADD_X2, 1'b0, mk(32'h77, 32'h20, 0, 0, 2, 1, 0, 0, 0),
           1, 5'd1, 32'h77, 1, 0, 1, 32'h20);
      step("mem_prio", SUB_X5, 1'b0, mk(32'h77, 32'h33, 1, 0, 5, 1, 0, 0, 0),
           0, 0, 0, 1, 0, 1, 32'hAA, 1, 5'd3, 32'h33);
      step("illegal", ILL, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      step("bubble", 32'd0, 1'b0, z);
`else
      step("addi_x3", ADDI_X3, 1'b0, mk(0, 3, 0, 0, 3, 1, 0, 0, 0));
      step("lw_wait", LW_X1, 1'b1, z);
      step("lw_wbbyp", LW_X1, 1'b0, mk(3, 100, 0, 0, 1, 1, 0, 1, 0), 1, 5'd3, 32'd3);
      step("addi_wait", ADDI_X2, 1'b1, z);
      step("addi_iss", ADDI_X2, 1'b0, mk(32'h55, 100, 0, 0, 2, 1, 0, 0, 0), 1, 5'd1, 32'h55);
      step("hold_en0", ADD_X2, 1'b0, mk(32'h55, 100, 0, 0, 2, 1, 0, 0, 0), 1, 5'd2, 32'h99, 0);
      step("add_wait", ADD_X2, 1'b1, z);
      step("add_iss", ADD_X2, 1'b0, mk(32'h55, 32'h10, 0, 0, 2, 1, 0, 0, 0), 1, 5'd2, 32'h10);
      step("sw", SW_X0, 1'b0, mk(0, 8, 0, 0, 0, 0, 1, 0, 0));
      step("illegal", ILL, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      step("bubble", 32'd0, 1'b0, z);
      step("addi_m1", ADDI_M1, 1'b0, mk(0, 32'hFFFFFFFF, 0, 0, 4, 1, 0, 0, 0));
      step("sub", SUB_X5, 1'b0, mk(32'h55, 3, 1, 0, 5, 1, 0, 0, 0));
      step("srai", SRAI_X6, 1'b0, mk(32'h55, 2, 7, 0, 6, 1, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         step("lui", LUI_X7, 1'b0, mk(0, 32'h12345000, 0, 0, 7, 1, 0, 0, 0));
      step("lui_sat", LUI_X7, 1'b1, z);
      step("lui_satwb", LUI_X7, 1'b0, mk(0, 32'h12345000, 0, 0, 7, 1, 0, 0, 0), 1, 5'd7, 32'd1);
      step("add_wait2", ADD_X2, 1'b1, z);
      step("rst_mid", ADD_X2, 1'b1, z, 0, 0, 0, 1, 1);
      step("after_rst", ADD_X2, 1'b0, mk(0, 0, 0, 0, 2, 1, 0, 0, 0));
`endif
      repeat (3) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
